code_lock_ctrl: RTL and testbench

//  Parametrised keypad code-entry lock controller; successor to the fixed single-digit "press 2" check.

---
 rtl/code_lock_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: keypad code-entry lock controller.
// Collects CODE_LEN digits from the keypad scanner and compares them with a
// programmable stored code. Counts consecutive failures and locks out after
// MAX_TRIES of them. Drives timed unlock, fail and lockout indications, and
// supports re-programming the code while unlocked.
module code_lock_ctrl #(
  parameter int                            CODE_LEN       = 4,
  parameter int                            DIGIT_W        = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1234,
  parameter logic [DIGIT_W-1:0]            CLEAR_KEY      = 4'hA,
  parameter int                            MAX_TRIES      = 3,
  parameter int                            UNLOCK_CYCLES  = 24_000_000,
  parameter int                            FAIL_CYCLES    = 6_000_000,
  parameter int                            LOCKOUT_CYCLES = 120_000_000,
  parameter int                            ENTRY_TIMEOUT  = 60_000_000
) (
  input  logic                              hwclk,
  input  logic                              rst_n,
  input  logic                              key_valid,
  input  logic [DIGIT_W-1:0]                key_code,
  input  logic                              prog_req,
  output logic                              unlocked,
  output logic                              fail,
  output logic                              lockout,
  output logic                              prog_active,
  output logic                              prog_done,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt,
  output logic [$clog2(MAX_TRIES+1)-1:0]    tries_left
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CODE_W = CODE_LEN * DIGIT_W;
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int T_MAX  = max2(max2(UNLOCK_CYCLES, FAIL_CYCLES),
                               max2(LOCKOUT_CYCLES, ENTRY_TIMEOUT));
  localparam int TMR_W  = $clog2(T_MAX + 1);

  // Timers are loaded with N-1 so that a state lasts exactly N cycles.
  localparam logic [TMR_W-1:0] LD_UNLOCK  = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_FAIL    = TMR_W'(FAIL_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_LOCKOUT = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] LD_ENTRY   = TMR_W'(ENTRY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CODE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [TRY_W-1:0] TRY_MAX    = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] TRY_ONE    = TRY_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_UNLOCKED,
    S_FAIL,
    S_LOCKOUT,
    S_PROG
  } state_t;

  state_t              r_state;
  logic [1:0]          r_rst_sync;
  logic [CODE_W-1:0]   r_code;
  logic [CODE_W-1:0]   r_buf;
  logic [CNT_W-1:0]    r_digit_cnt;
  logic [TRY_W-1:0]    r_tries;
  logic [TMR_W-1:0]    r_timer;
  logic                r_unlocked;
  logic                r_fail;
  logic                r_lockout;
  logic                r_prog_active;
  logic                r_prog_done;

  logic                w_rst_n;
  logic                w_key_digit;
  logic                w_key_clear;
  logic                w_last_digit;
  logic                w_tmr_zero;
  logic                w_code_match;
  logic [CODE_W-1:0]   w_buf_next;
  logic [CNT_W-1:0]    w_cnt_next;

  // Reset synchronizer: assertion is immediate, release aligned to hwclk.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n      = r_rst_sync[1];
  assign w_key_digit  = key_valid && (key_code != CLEAR_KEY);
  assign w_key_clear  = key_valid && (key_code == CLEAR_KEY);
  assign w_last_digit = (r_digit_cnt == CNT_LAST);
  assign w_tmr_zero   = (r_timer == TMR_ZERO);
  assign w_code_match = (r_buf == r_code);
  // New digit shifts in at the LS end, so the first-entered digit ends up MS.
  assign w_buf_next   = (r_buf << DIGIT_W) | CODE_W'(key_code);
  assign w_cnt_next   = r_digit_cnt + CNT_ONE;

  // Lock FSM: state, timer, entry buffer, stored code, try counter and flags.
  always_ff @(posedge hwclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= S_IDLE;
      r_code        <= DEFAULT_CODE;
      r_buf         <= '0;
      r_digit_cnt   <= '0;
      r_tries       <= TRY_MAX;
      r_timer       <= '0;
      r_unlocked    <= 1'b0;
      r_fail        <= 1'b0;
      r_lockout     <= 1'b0;
      r_prog_active <= 1'b0;
      r_prog_done   <= 1'b0;
    end else begin
      r_prog_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // CLEAR in IDLE is ignored; any other key starts an entry.
          if (w_key_digit) begin
            r_buf       <= w_buf_next;
            r_digit_cnt <= CNT_ONE;
            if (w_last_digit) begin
              r_state <= S_CHECK;
              r_timer <= TMR_ZERO;
            end else begin
              r_state <= S_ENTRY;
              r_timer <= LD_ENTRY;
            end
          end
        end

        S_ENTRY: begin
          if (w_key_digit) begin
            r_buf       <= w_buf_next;
            r_digit_cnt <= w_cnt_next;
            if (w_last_digit) begin
              r_state <= S_CHECK;
              r_timer <= TMR_ZERO;
            end else begin
              r_timer <= LD_ENTRY;
            end
          end else if (w_key_clear || w_tmr_zero) begin
            // Abort or idle gap exceeded: discard without counting an attempt.
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_digit_cnt <= '0;
            r_timer     <= TMR_ZERO;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end

        S_CHECK: begin
          r_buf       <= '0;
          r_digit_cnt <= '0;
          if (w_code_match) begin
            r_state    <= S_UNLOCKED;
            r_tries    <= TRY_MAX;
            r_unlocked <= 1'b1;
            r_timer    <= LD_UNLOCK;
          end else if (r_tries <= TRY_ONE) begin
            r_state   <= S_LOCKOUT;
            r_tries   <= '0;
            r_lockout <= 1'b1;
            r_timer   <= LD_LOCKOUT;
          end else begin
            r_state <= S_FAIL;
            r_tries <= r_tries - TRY_ONE;
            r_fail  <= 1'b1;
            r_timer <= LD_FAIL;
          end
        end

        S_UNLOCKED: begin
          // A programming request takes priority over the hold-time expiry.
          if (prog_req) begin
            r_state       <= S_PROG;
            r_unlocked    <= 1'b0;
            r_prog_active <= 1'b1;
            r_buf         <= '0;
            r_digit_cnt   <= '0;
            r_timer       <= LD_ENTRY;
          end else if (w_tmr_zero) begin
            r_state    <= S_IDLE;
            r_unlocked <= 1'b0;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end

        S_FAIL: begin
          if (w_tmr_zero) begin
            r_state <= S_IDLE;
            r_fail  <= 1'b0;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end

        S_LOCKOUT: begin
          if (w_tmr_zero) begin
            r_state   <= S_IDLE;
            r_lockout <= 1'b0;
            r_tries   <= TRY_MAX;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end

        S_PROG: begin
          if (w_key_digit) begin
            if (w_last_digit) begin
              // Final digit: commit the new code and return to IDLE.
              r_code        <= w_buf_next;
              r_prog_done   <= 1'b1;
              r_prog_active <= 1'b0;
              r_state       <= S_IDLE;
              r_buf         <= '0;
              r_digit_cnt   <= '0;
              r_timer       <= TMR_ZERO;
            end else begin
              r_buf       <= w_buf_next;
              r_digit_cnt <= w_cnt_next;
              r_timer     <= LD_ENTRY;
            end
          end else if (w_key_clear || w_tmr_zero) begin
            // Abandon programming; stored code stays as it was.
            r_state       <= S_IDLE;
            r_prog_active <= 1'b0;
            r_buf         <= '0;
            r_digit_cnt   <= '0;
            r_timer       <= TMR_ZERO;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end

        default: begin
          r_state       <= S_IDLE;
          r_buf         <= '0;
          r_digit_cnt   <= '0;
          r_timer       <= TMR_ZERO;
          r_unlocked    <= 1'b0;
          r_fail        <= 1'b0;
          r_lockout     <= 1'b0;
          r_prog_active <= 1'b0;
        end
      endcase
    end
  end

  assign unlocked    = r_unlocked;
  assign fail        = r_fail;
  assign lockout     = r_lockout;
  assign prog_active = r_prog_active;
  assign prog_done   = r_prog_done;
  assign digit_cnt   = r_digit_cnt;
  assign tries_left  = r_tries;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed testbench for code_lock_ctrl with short timers (20 cycles, 15 entry timeout).
module tb_code_lock_ctrl;

  logic       hwclk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       prog_req;
  logic       unlocked;
  logic       fail;
  logic       lockout;
  logic       prog_active;
  logic       prog_done;
  logic [2:0] digit_cnt;
  logic [1:0] tries_left;

  int vecs;
  int errs;

  code_lock_ctrl #(
    .CODE_LEN       (4),
    .DIGIT_W        (4),
    .DEFAULT_CODE   (16'h1234),
    .CLEAR_KEY      (4'hA),
    .MAX_TRIES      (3),
    .UNLOCK_CYCLES  (20),
    .FAIL_CYCLES    (20),
    .LOCKOUT_CYCLES (20),
    .ENTRY_TIMEOUT  (15)
  ) dut (
    .hwclk       (hwclk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .prog_req    (prog_req),
    .unlocked    (unlocked),
    .fail        (fail),
    .lockout     (lockout),
    .prog_active (prog_active),
    .prog_done   (prog_done),
    .digit_cnt   (digit_cnt),
    .tries_left  (tries_left)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vecs);
    $fatal(1, "watchdog");
  end

  // One key strobe; returns at the falling edge just after it was sampled.
  task automatic press(input logic [3:0] k);
    @(negedge hwclk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge hwclk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    press(a);
    press(b);
    press(c);
    press(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic drain;
    idle(22);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    idle(2);
    vecs++;
    if ({unlocked, fail, lockout, prog_active, prog_done} !== 5'b0) begin
      errs++;
      $display("FAIL reset_flags: got %b expected 00000",
               {unlocked, fail, lockout, prog_active, prog_done});
    end
    vecs++;
    if (digit_cnt !== 3'd0) begin
      errs++; $display("FAIL reset_digit_cnt: got %0d expected 0", digit_cnt);
    end
    vecs++;
    if (tries_left !== 2'd3) begin
      errs++; $display("FAIL reset_tries: got %0d expected 3", tries_left);
    end
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_unlock;
    int hi;
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    vecs++;
    if (unlocked !== 1'b0 || digit_cnt !== 3'd4) begin
      errs++;
      $display("FAIL unlock_latency: unlocked=%0b digit_cnt=%0d expected 0 and 4", unlocked, digit_cnt);
    end
    @(negedge hwclk);
    vecs++;
    if (unlocked !== 1'b1 || tries_left !== 2'd3 || digit_cnt !== 3'd0) begin
      errs++;
      $display("FAIL unlock_rise: unlocked=%0b tries=%0d cnt=%0d expected 1,3,0", unlocked, tries_left, digit_cnt);
    end
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge hwclk);
      if (unlocked === 1'b1) hi++;
      else break;
    end
    vecs++;
    if (hi != 20) begin
      errs++; $display("FAIL unlock_duration: got %0d cycles expected 20", hi);
    end
  endtask

  task automatic test_fail;
    int hi;
    enter4(4'h1, 4'h2, 4'h3, 4'h5);
    @(negedge hwclk);
    vecs++;
    if (fail !== 1'b1 || unlocked !== 1'b0 || tries_left !== 2'd2) begin
      errs++;
      $display("FAIL fail_rise: fail=%0b unlocked=%0b tries=%0d expected 1,0,2", fail, unlocked, tries_left);
    end
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge hwclk);
      if (fail === 1'b1) hi++;
      else break;
    end
    vecs++;
    if (hi != 20) begin
      errs++; $display("FAIL fail_duration: got %0d cycles expected 20", hi);
    end
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge hwclk);
    vecs++;
    if (unlocked !== 1'b1 || tries_left !== 2'd3) begin
      errs++;
      $display("FAIL fail_then_unlock: unlocked=%0b tries=%0d expected 1,3", unlocked, tries_left);
    end
    drain();
  endtask

  task automatic test_lockout;
    enter4(4'h9, 4'h9, 4'h9, 4'h9);
    @(negedge hwclk);
    drain();
    enter4(4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge hwclk);
    vecs++;
    if (fail !== 1'b1 || tries_left !== 2'd1) begin
      errs++; $display("FAIL second_wrong: fail=%0b tries=%0d expected 1,1", fail, tries_left);
    end
    drain();
    enter4(4'h4, 4'h3, 4'h2, 4'h1);
    @(negedge hwclk);
    vecs++;
    if (lockout !== 1'b1 || fail !== 1'b0 || tries_left !== 2'd0) begin
      errs++;
      $display("FAIL lockout_rise: lockout=%0b fail=%0b tries=%0d expected 1,0,0", lockout, fail, tries_left);
    end
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    vecs++;
    if (digit_cnt !== 3'd0 || unlocked !== 1'b0 || lockout !== 1'b1) begin
      errs++;
      $display("FAIL lockout_keys_ignored: cnt=%0d unlocked=%0b lockout=%0b expected 0,0,1", digit_cnt, unlocked, lockout);
    end
    idle(11);
    vecs++;
    if (lockout !== 1'b1) begin
      errs++; $display("FAIL lockout_last_cycle: lockout=%0b expected 1", lockout);
    end
    idle(1);
    vecs++;
    if (lockout !== 1'b0 || tries_left !== 2'd3 || unlocked !== 1'b0) begin
      errs++;
      $display("FAIL lockout_end: lockout=%0b tries=%0d unlocked=%0b expected 0,3,0", lockout, tries_left, unlocked);
    end
  endtask

  task automatic test_clear_timeout;
    press(4'hA);
    vecs++;
    if (digit_cnt !== 3'd0) begin
      errs++; $display("FAIL idle_clear: cnt=%0d expected 0", digit_cnt);
    end
    press(4'h1);
    press(4'h2);
    press(4'hA);
    vecs++;
    if (digit_cnt !== 3'd0) begin
      errs++; $display("FAIL entry_clear: cnt=%0d expected 0", digit_cnt);
    end
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge hwclk);
    vecs++;
    if (unlocked !== 1'b1 || tries_left !== 2'd3) begin
      errs++; $display("FAIL clear_then_unlock: unlocked=%0b tries=%0d expected 1,3", unlocked, tries_left);
    end
    drain();
    press(4'h1);
    press(4'h2);
    vecs++;
    if (digit_cnt !== 3'd2) begin
      errs++; $display("FAIL partial_entry: cnt=%0d expected 2", digit_cnt);
    end
    idle(14);
    vecs++;
    if (digit_cnt !== 3'd2) begin
      errs++; $display("FAIL before_timeout: cnt=%0d expected 2", digit_cnt);
    end
    idle(2);
    vecs++;
    if (digit_cnt !== 3'd0 || tries_left !== 2'd3 || fail !== 1'b0) begin
      errs++;
      $display("FAIL after_timeout: cnt=%0d tries=%0d fail=%0b expected 0,3,0", digit_cnt, tries_left, fail);
    end
  endtask

  task automatic test_prog;
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge hwclk);
    idle(2);
    prog_req = 1'b1;
    @(negedge hwclk);
    prog_req = 1'b0;
    vecs++;
    if (prog_active !== 1'b1 || unlocked !== 1'b0) begin
      errs++; $display("FAIL prog_enter: prog_active=%0b unlocked=%0b expected 1,0", prog_active, unlocked);
    end
    press(4'h9);
    press(4'h8);
    press(4'h7);
    vecs++;
    if (digit_cnt !== 3'd3 || prog_done !== 1'b0) begin
      errs++; $display("FAIL prog_partial: cnt=%0d prog_done=%0b expected 3,0", digit_cnt, prog_done);
    end
    press(4'h6);
    vecs++;
    if (prog_done !== 1'b1 || prog_active !== 1'b0) begin
      errs++; $display("FAIL prog_done_pulse: prog_done=%0b prog_active=%0b expected 1,0", prog_done, prog_active);
    end
    @(negedge hwclk);
    vecs++;
    if (prog_done !== 1'b0) begin
      errs++; $display("FAIL prog_done_width: prog_done=%0b expected 0", prog_done);
    end
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge hwclk);
    vecs++;
    if (fail !== 1'b1 || unlocked !== 1'b0) begin
      errs++; $display("FAIL old_code_rejected: fail=%0b unlocked=%0b expected 1,0", fail, unlocked);
    end
    drain();
    enter4(4'h9, 4'h8, 4'h7, 4'h6);
    @(negedge hwclk);
    vecs++;
    if (unlocked !== 1'b1 || tries_left !== 2'd3) begin
      errs++; $display("FAIL new_code_accepted: unlocked=%0b tries=%0d expected 1,3", unlocked, tries_left);
    end
    drain();
  endtask

  task automatic test_reset_mid_prog;
    enter4(4'h9, 4'h8, 4'h7, 4'h6);
    @(negedge hwclk);
    prog_req = 1'b1;
    @(negedge hwclk);
    prog_req = 1'b0;
    press(4'h5);
    press(4'h5);
    vecs++;
    if (prog_active !== 1'b1 || digit_cnt !== 3'd2) begin
      errs++; $display("FAIL mid_prog_state: prog_active=%0b cnt=%0d expected 1,2", prog_active, digit_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (prog_active !== 1'b0 || digit_cnt !== 3'd0 || tries_left !== 2'd3 || prog_done !== 1'b0) begin
      errs++;
      $display("FAIL async_reset: prog_active=%0b cnt=%0d tries=%0d done=%0b expected 0,0,3,0",
               prog_active, digit_cnt, tries_left, prog_done);
    end
    @(negedge hwclk);
    rst_n = 1'b1;
    idle(3);
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge hwclk);
    vecs++;
    if (unlocked !== 1'b1) begin
      errs++; $display("FAIL default_code_restored: unlocked=%0b expected 1", unlocked);
    end
    drain();
  endtask

  task automatic test_prog_at_expiry;
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge hwclk);
    idle(19);
    vecs++;
    if (unlocked !== 1'b1) begin
      errs++; $display("FAIL unlock_final_cycle: unlocked=%0b expected 1", unlocked);
    end
    prog_req = 1'b1;
    @(negedge hwclk);
    prog_req = 1'b0;
    vecs++;
    if (prog_active !== 1'b1 || unlocked !== 1'b0) begin
      errs++; $display("FAIL prog_wins_expiry: prog_active=%0b unlocked=%0b expected 1,0", prog_active, unlocked);
    end
    press(4'h7);
    press(4'hA);
    vecs++;
    if (prog_active !== 1'b0 || prog_done !== 1'b0 || digit_cnt !== 3'd0) begin
      errs++;
      $display("FAIL prog_abort: prog_active=%0b done=%0b cnt=%0d expected 0,0,0", prog_active, prog_done, digit_cnt);
    end
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge hwclk);
    vecs++;
    if (unlocked !== 1'b1) begin
      errs++; $display("FAIL code_kept_after_abort: unlocked=%0b expected 1", unlocked);
    end
    drain();
  endtask

  initial begin
    vecs      = 0;
    errs      = 0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    prog_req  = 1'b0;
    rst_n     = 1'b1;
    test_reset();
    test_unlock();
    test_fail();
    test_lockout();
    test_clear_timeout();
    test_prog();
    test_reset_mid_prog();
    test_prog_at_expiry();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
